// File: rtl/base_conv_scheduler.sv
// base_conv_scheduler
//   Shares one combinational base converter between NUM_REQ requesters.
//   A round-robin arbiter picks one request in IDLE. The chosen mode/data are
//   registered onto the converter inputs, and the converter result is captured
//   one cycle later. The result is then offered on a valid/ready response port,
//   tagged with the requester index. Only one request is in flight at a time.
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req_valid/req_mode/req_data  per-requester request, slot i packed at index i
//   req_ready                    one-hot accept strobe (IDLE only, combinational)
//   conv_mode/conv_data_in       registered converter inputs (held while idle)
//   conv_data_out/conv_valid     converter result
//   rsp_valid/rsp_ready          response handshake
//   rsp_id/rsp_data/rsp_err      response payload (rsp_err = ~conv_valid)
//   busy                         high whenever not IDLE
//   err_count                    saturating count of error responses
module base_conv_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [3*NUM_REQ-1:0]    req_mode,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [2:0]              conv_mode,
  output logic [15:0]             conv_data_in,
  input  logic [15:0]             conv_data_out,
  input  logic                    conv_valid,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state;
  logic [ID_W-1:0]          last;
  logic                     gnt_found;
  logic [ID_W-1:0]          gnt_idx;
  logic [NUM_REQ-1:0][2:0]  mode_arr;
  logic [NUM_REQ-1:0][15:0] data_arr;

  // Flat buses reinterpreted as per-slot arrays (bit layouts are identical).
  assign mode_arr = req_mode;
  assign data_arr = req_data;

  // Round robin: scan last+1, last+2, ... wrapping, first set bit wins.
  // The scan ends at last itself, so a lone requester can win back-to-back.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(last) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= ID_W'(NUM_REQ - 1);
      conv_mode    <= '0;
      conv_data_in <= '0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_found) begin
          conv_mode    <= mode_arr[gnt_idx];
          conv_data_in <= data_arr[gnt_idx];
          rsp_id       <= gnt_idx;
          last         <= gnt_idx;
          state        <= EXEC;
        end
        EXEC: begin
          // Data is passed through as-is even on error (converter drives 0).
          rsp_data <= conv_data_out;
          rsp_err  <= ~conv_valid;
          if (!conv_valid && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
          state    <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
